chord_mixer: RTL and testbench
==============================

Name: chord_mixer

Overview:
- Parametrised N-voice sample mixer; successor to the fixed three-voice chord summing path.
- Sits between the per-voice note players and codec_conditioner.
- Collects one sample per active voice per sample period, with a per-voice ready handshake and a timeout.
- Sums the collected samples sequentially in a wide accumulator, then saturates, or scales and saturates, into one output sample with a valid pulse.

Parameters:
- NUM_VOICES, 3: number of voice inputs (>=1).
- SAMPLE_WIDTH, 16: signed sample width.
- SHIFT, 2: arithmetic right shift applied in scale mode.
- TIMEOUT, 64: maximum COLLECT cycles before missing voices are treated as zero (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- generate_next_sample  input  1  single-cycle pulse that starts a sample period
- voice_sample  input  NUM_VOICES*SAMPLE_WIDTH  packed signed samples; voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- voice_ready  input  NUM_VOICES  voice i sample valid this cycle
- voice_active  input  NUM_VOICES  voice participation mask
- mode  input  1  0 = saturate; 1 = arithmetic shift right by SHIFT, then saturate
- mixed_sample  output  SAMPLE_WIDTH  signed mixed result
- mixed_valid  output  1  one-cycle pulse, mixed_sample updated
- missed_voices  output  NUM_VOICES  active voices that timed out in the last frame
- overrun  output  1  one-cycle pulse, generate_next_sample arrived while busy
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; accumulator, timer, got mask and sample latches cleared. Reset mid-frame abandons the frame; no mixed_valid is issued for it.
- Accumulator width: SAMPLE_WIDTH + clog2(NUM_VOICES) + 1, signed. Every voice sample is sign-extended before adding.
- IDLE:
  - On generate_next_sample: capture voice_active into active_q and mode into mode_q.
  - Clear got mask and timer.
  - In this same cycle, latch any voice i with voice_ready[i] & voice_active[i], setting got[i].
  - Go to COLLECT.
- COLLECT:
  - Each cycle, latch voice i if voice_ready[i] & active_q[i] & ~got[i]. The first sample per voice wins; later readies are ignored.
  - Readies for voices outside active_q are ignored.
  - Timer increments each COLLECT cycle.
  - Exit to ACCUM when (got | latches this cycle) == active_q, or when timer == TIMEOUT-1.
  - On exit, missed_voices <= active_q & ~got_final. Missing voices contribute 0.
  - An empty active_q exits after one COLLECT cycle and yields 0.
- ACCUM:
  - Exactly NUM_VOICES cycles, index 0..NUM_VOICES-1.
  - acc += got[i] ? sext(sample_i) : 0.
  - The final cycle computes the result into mixed_sample:
    - mode_q=0: saturate acc to [-2^(W-1), 2^(W-1)-1].
    - mode_q=1: acc >>> SHIFT (floor toward -inf), then saturate.
- OUTPUT: one cycle; mixed_valid=1; next state IDLE. mixed_sample holds its value until the next frame's OUTPUT.
- Latency with all voices ready in the start cycle:
  - generate_next_sample at cycle 0.
  - COLLECT at cycle 1.
  - ACCUM at cycles 2..NUM_VOICES+1.
  - mixed_valid at cycle NUM_VOICES+2.
- generate_next_sample while busy: ignored (no restart, frame state unaffected); overrun pulses the following cycle.
- generate_next_sample in the OUTPUT cycle is also an overrun. The next frame starts only from IDLE.
- mode and voice_active changes mid-frame have no effect; both are captured at start.

Test Plan:
1. NUM_VOICES=3, W=16, mode=0, active=3'b111, samples 1000/2000/-500, all ready in the gen cycle -> mixed_sample=2500, mixed_valid at cycle 5 only, missed_voices=0.
2. Samples 30000/30000/10000 -> 32767; samples -30000/-30000/-30000 -> -32768; each with a single mixed_valid.
3. mode=1, SHIFT=2, samples 30000/30000/10000 -> 17500; samples -3/0/0 -> -1.
4. TIMEOUT=8, voice 2 never ready, voices 0/1 = 100/200 -> COLLECT cycles 1..8, mixed_valid at cycle 12, mixed_sample=300, missed_voices=3'b100.
5. Staggered readies:
   - Voice 1 ready at cycle 3; voice 0 ready twice (first value 5, then 9); voice 2 inactive but ready.
   - Expected: result = 5 + voice1 sample.
   - Then: gen pulsed at cycle 2 -> overrun=1 at cycle 3, frame result unchanged.
6. Reset asserted during ACCUM -> all outputs 0 immediately and no mixed_valid for that frame; next gen with active=0 -> mixed_sample=0, mixed_valid at cycle 5.

Source files
------------

// File: rtl/chord_mixer_if.sv
// chord_mixer_if: voice inputs, frame control and mixed output of the chord mixer
interface chord_mixer_if #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16
);
    logic                                 generate_next_sample;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_sample;
    logic [NUM_VOICES-1:0]                voice_ready;
    logic [NUM_VOICES-1:0]                voice_active;
    logic                                 mode;
    logic signed [SAMPLE_WIDTH-1:0]       mixed_sample;
    logic                                 mixed_valid;
    logic [NUM_VOICES-1:0]                missed_voices;
    logic                                 overrun;
    logic                                 busy;

    modport master (
        output generate_next_sample, voice_sample, voice_ready, voice_active, mode,
        input  mixed_sample, mixed_valid, missed_voices, overrun, busy
    );
    modport slave (
        input  generate_next_sample, voice_sample, voice_ready, voice_active, mode,
        output mixed_sample, mixed_valid, missed_voices, overrun, busy
    );
endinterface

// File: rtl/chord_mixer.sv
// chord_mixer: collects one sample per active voice, sums them sequentially, then saturates or scales+saturates
module chord_mixer #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SHIFT        = 2,
    parameter int TIMEOUT      = 64
) (
    input logic          clk,
    input logic          reset,
    chord_mixer_if.slave bus
);
    localparam int W  = SAMPLE_WIDTH;
    localparam int N  = NUM_VOICES;
    localparam int AW = W + $clog2(N) + 1;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, ACCUM, OUTPUT} state_t;

    state_t                state, state_nx;
    logic [N-1:0]          active_q, got, lat, take, got_final, missed_q;
    logic                  mode_q, overrun_q, collect_done, last;
    logic signed [W-1:0]   samp [N];
    logic [TW-1:0]         timer;
    logic [IW-1:0]         idx;
    logic signed [AW-1:0]  acc, sum, scaled;
    logic signed [W-1:0]   sat, mixed_q;

    always_comb begin
        // In IDLE the got mask is logically cleared, so only the live active mask gates readies
        lat = bus.voice_ready & (state == IDLE ? bus.voice_active : active_q & ~got);
        take = lat & {N{state == IDLE ? bus.generate_next_sample : state == COLLECT}};
        got_final = got | lat;
        collect_done = got_final == active_q || timer == TW'(TIMEOUT - 1);
        last = idx == IW'(N - 1);
        sum = acc + (got[idx] ? AW'(samp[idx]) : '0);
        scaled = mode_q ? sum >>> SHIFT : sum;
        sat = scaled > SMAX ? SMAX[W-1:0] : scaled < SMIN ? SMIN[W-1:0] : scaled[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.generate_next_sample ? COLLECT : IDLE;
            COLLECT: state_nx = collect_done ? ACCUM : COLLECT;
            ACCUM:   state_nx = last ? OUTPUT : ACCUM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            mode_q    <= 1'b0;
            got       <= '0;
            timer     <= '0;
            idx       <= '0;
            acc       <= '0;
            mixed_q   <= '0;
            missed_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) samp[i] <= '0;
        end else begin
            overrun_q <= bus.generate_next_sample && state != IDLE;
            for (int i = 0; i < N; i++)
                if (take[i]) samp[i] <= bus.voice_sample[i*W +: W];
            case (state)
                IDLE: if (bus.generate_next_sample) begin
                    active_q <= bus.voice_active;
                    mode_q   <= bus.mode;
                    got      <= lat;
                    timer    <= '0;
                    idx      <= '0;
                    acc      <= '0;
                end
                COLLECT: begin
                    got   <= got_final;
                    timer <= timer + TW'(1);
                    if (collect_done) missed_q <= active_q & ~got_final;
                end
                ACCUM: begin
                    acc <= sum;
                    idx <= idx + IW'(1);
                    if (last) mixed_q <= sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.mixed_sample  = mixed_q;
    assign bus.mixed_valid   = state == OUTPUT;
    assign bus.missed_voices = missed_q;
    assign bus.overrun       = overrun_q;
    assign bus.busy          = state != IDLE;
endmodule

// File: tb/tb_chord_mixer.sv
// tb_chord_mixer: directed frames for the three-voice mixer with hand-computed results
module tb_chord_mixer;
    localparam int NV = 3;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   seen;

    chord_mixer_if #(.NUM_VOICES(NV), .SAMPLE_WIDTH(W)) bus ();

    chord_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(W), .SHIFT(2), .TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_samples(input int s0, input int s1, input int s2);
        logic [W-1:0] a, b, c;
        a = W'(s0);
        b = W'(s1);
        c = W'(s2);
        bus.voice_sample = {c, b, a};
    endtask

    task automatic wait_valid();
        while (!bus.mixed_valid && cyc < 40) tick();
    endtask

    task automatic all_ready_frame(input logic md, input int s0, input int s1, input int s2,
                                   input int exp, input string tag);
        set_samples(s0, s1, s2);
        bus.mode = md;
        bus.voice_active = 3'b111;
        bus.voice_ready = 3'b111;
        bus.generate_next_sample = 1'b1;
        cyc = 0;
        tick();
        bus.generate_next_sample = 1'b0;
        bus.voice_ready = 3'b000;
        check({tag, "_busy"}, bus.busy, 1);
        wait_valid();
        check({tag, "_valid_cycle"}, cyc, 5);
        check({tag, "_sample"}, bus.mixed_sample, exp);
        check({tag, "_missed"}, bus.missed_voices, 0);
        tick();
        check({tag, "_valid_single"}, bus.mixed_valid, 0);
    endtask

    initial begin
        bus.generate_next_sample = 1'b0;
        bus.voice_sample = '0;
        bus.voice_ready = '0;
        bus.voice_active = '0;
        bus.mode = 1'b0;
        tick();
        tick();
        check("rst_sample", bus.mixed_sample, 0);
        check("rst_valid", bus.mixed_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_missed", bus.missed_voices, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1'b0;
        tick();

        // plain sum, positive and negative saturation, scale mode
        all_ready_frame(1'b0, 1000, 2000, -500, 2500, "sum");
        all_ready_frame(1'b0, 30000, 30000, 10000, 32767, "sat_pos");
        all_ready_frame(1'b0, -30000, -30000, -30000, -32768, "sat_neg");
        all_ready_frame(1'b1, 30000, 30000, 10000, 17500, "scale_pos");
        all_ready_frame(1'b1, -3, 0, 0, -1, "scale_floor");

        // voice 2 never ready: timeout after 8 COLLECT cycles
        set_samples(100, 200, 999);
        bus.mode = 1'b0;
        bus.voice_active = 3'b111;
        bus.voice_ready = 3'b011;
        bus.generate_next_sample = 1'b1;
        cyc = 0;
        tick();
        bus.generate_next_sample = 1'b0;
        bus.voice_ready = 3'b000;
        while (cyc < 8) tick();
        check("tmo_busy_c8", bus.busy, 1);
        check("tmo_novalid_c8", bus.mixed_valid, 0);
        wait_valid();
        check("tmo_valid_cycle", cyc, 12);
        check("tmo_sample", bus.mixed_sample, 300);
        check("tmo_missed", bus.missed_voices, 3'b100);
        tick();

        // staggered readies, first sample wins, inactive voice ignored, overrun while busy
        bus.voice_active = 3'b011;
        set_samples(5, 0, 7777);
        bus.voice_ready = 3'b101;
        bus.generate_next_sample = 1'b1;
        cyc = 0;
        tick();
        bus.generate_next_sample = 1'b0;
        bus.voice_active = 3'b111;
        set_samples(9, 0, 7777);
        bus.voice_ready = 3'b101;
        tick();
        bus.voice_ready = 3'b000;
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
        check("ovr_pulse", bus.overrun, 1);
        set_samples(9, 40, 7777);
        bus.voice_ready = 3'b010;
        tick();
        bus.voice_ready = 3'b000;
        check("ovr_single", bus.overrun, 0);
        wait_valid();
        check("stag_valid_cycle", cyc, 7);
        check("stag_sample", bus.mixed_sample, 45);
        check("stag_missed", bus.missed_voices, 0);
        tick();

        // reset during ACCUM abandons the frame
        set_samples(11, 22, 33);
        bus.voice_active = 3'b111;
        bus.voice_ready = 3'b111;
        bus.generate_next_sample = 1'b1;
        cyc = 0;
        tick();
        bus.generate_next_sample = 1'b0;
        bus.voice_ready = 3'b000;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_sample", bus.mixed_sample, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.mixed_valid, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            seen += int'(bus.mixed_valid);
        end
        check("mid_rst_no_valid", seen, 0);

        // empty active mask, then gen during OUTPUT is an overrun
        bus.voice_active = 3'b000;
        bus.voice_ready = 3'b111;
        bus.generate_next_sample = 1'b1;
        cyc = 0;
        tick();
        bus.generate_next_sample = 1'b0;
        bus.voice_ready = 3'b000;
        wait_valid();
        check("empty_valid_cycle", cyc, 5);
        check("empty_sample", bus.mixed_sample, 0);
        check("empty_missed", bus.missed_voices, 0);
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
        check("out_ovr_pulse", bus.overrun, 1);
        check("out_ovr_idle", bus.busy, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
